// File: rtl/swacc_ctx_wr_ctl.sv
// swacc_ctx_wr_ctl: turns CEU context write/invalidate commands into ICM cache set/delete requests
module swacc_ctx_wr_ctl #(
    parameter int         DATA_WIDTH     = 256,
    parameter int         HEAD_WIDTH     = 128,
    parameter int         PIECE_NUM      = 2,
    parameter int         ENTRY_WIDTH    = 512,
    parameter int         INDEX_WIDTH    = 20,
    parameter int         ICM_ADDR_WIDTH = 64,
    parameter int         PHY_ADDR_WIDTH = 64,
    parameter int         TAG_WIDTH      = 6,
    parameter int         COUNT_MAX_LOG  = 3,
    parameter logic [3:0] OPC_WRITE      = 4'h1,
    parameter logic [3:0] OPC_INVALID    = 4'h2
) (
    input  logic                                                                  clk,
    input  logic                                                                  rst_n,
    input  logic                                                                  req_valid,
    input  logic [HEAD_WIDTH-1:0]                                                 req_head,
    input  logic                                                                  req_last,
    input  logic [DATA_WIDTH-1:0]                                                 req_data,
    output logic                                                                  req_ready,
    output logic                                                                  lookup_valid,
    output logic [INDEX_WIDTH-1:0]                                                lookup_head,
    input  logic                                                                  lookup_ready,
    input  logic                                                                  rsp_valid,
    input  logic [ICM_ADDR_WIDTH-1:0]                                             rsp_icm_addr,
    input  logic [PHY_ADDR_WIDTH-1:0]                                             rsp_phy_addr,
    output logic                                                                  rsp_ready,
    output logic                                                                  set_valid,
    output logic [TAG_WIDTH+2*COUNT_MAX_LOG+ICM_ADDR_WIDTH+PHY_ADDR_WIDTH-1:0]    set_head,
    output logic [ENTRY_WIDTH-1:0]                                                set_data,
    input  logic                                                                  set_ready,
    output logic                                                                  del_valid,
    output logic [TAG_WIDTH+ICM_ADDR_WIDTH+PHY_ADDR_WIDTH-1:0]                    del_head,
    input  logic                                                                  del_ready,
    output logic                                                                  err_valid,
    output logic [1:0]                                                            err_code,
    output logic                                                                  busy
);
    localparam int CW = $clog2(PIECE_NUM + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(PIECE_NUM - 1);

    typedef enum logic [2:0] {IDLE, ADDR_REQ, ADDR_RSP, COLLECT, CACHE_SET, CACHE_DEL, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [INDEX_WIDTH-1:0]    idx_q, idx_d;
    logic                      wr_q, wr_d;
    logic [ICM_ADDR_WIDTH-1:0] icm_q, icm_d;
    logic [PHY_ADDR_WIDTH-1:0] phy_q, phy_d;
    logic [ENTRY_WIDTH-1:0]    entry_q, entry_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      del_done_q, del_done_d;
    logic                      last_done_q, last_done_d;
    logic                      err_valid_q, err_valid_d;
    logic [1:0]                err_code_q, err_code_d;
    logic [3:0]                opc;
    logic                      beat, del_fire, unused_head;

    assign opc         = req_head[123:120];
    assign unused_head = ^req_head;
    assign beat        = req_valid && req_ready;
    assign del_fire    = del_valid && del_ready;

    // In CACHE_DEL the payload and the delete handshake complete independently; each is gated once done
    assign req_ready    = state_q == COLLECT || state_q == DRAIN || (state_q == CACHE_DEL && !last_done_q);
    assign lookup_valid = state_q == ADDR_REQ;
    assign lookup_head  = lookup_valid ? idx_q : '0;
    assign rsp_ready    = state_q == ADDR_RSP;
    assign set_valid    = state_q == CACHE_SET;
    assign set_head     = set_valid ? {TAG_WIDTH'(0), COUNT_MAX_LOG'(1), COUNT_MAX_LOG'(0), phy_q, icm_q} : '0;
    assign set_data     = entry_q;
    assign del_valid    = state_q == CACHE_DEL && !del_done_q;
    assign del_head     = del_valid ? {TAG_WIDTH'(0), phy_q, icm_q} : '0;
    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;
    assign busy         = state_q != IDLE;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_d        = wr_q;
        icm_d       = icm_q;
        phy_d       = phy_q;
        entry_d     = entry_q;
        cnt_d       = cnt_q;
        del_done_d  = del_done_q || del_fire;
        last_done_d = last_done_q || (state_q == CACHE_DEL && beat && req_last);
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        case (state_q)
            IDLE: if (req_valid) begin
                idx_d = req_head[64 +: INDEX_WIDTH];
                wr_d  = opc == OPC_WRITE;
                if (opc == OPC_WRITE || opc == OPC_INVALID) begin
                    state_d = ADDR_REQ;
                end else begin
                    state_d     = DRAIN;
                    err_valid_d = 1'b1;
                    err_code_d  = 2'd1;
                end
            end
            ADDR_REQ: if (lookup_ready) state_d = ADDR_RSP;
            ADDR_RSP: if (rsp_valid) begin
                icm_d   = rsp_icm_addr;
                phy_d   = rsp_phy_addr;
                state_d = wr_q ? COLLECT : CACHE_DEL;
            end
            COLLECT: if (beat) begin
                for (int i = 0; i < PIECE_NUM; i++)
                    if (cnt_q == CW'(i)) entry_d[i*DATA_WIDTH +: DATA_WIDTH] = req_data;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BEAT) begin
                    state_d     = req_last ? CACHE_SET : DRAIN;
                    err_valid_d = !req_last;
                    err_code_d  = req_last ? err_code_q : 2'd3;
                end else if (req_last) begin
                    state_d     = IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = 2'd2;
                end
            end
            CACHE_SET: if (set_ready) state_d = IDLE;
            CACHE_DEL: if (del_done_d && last_done_d) state_d = IDLE;
            DRAIN: if (beat && req_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) begin
            icm_d       = '0;
            phy_d       = '0;
            entry_d     = '0;
            cnt_d       = '0;
            del_done_d  = 1'b0;
            last_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wr_q        <= 1'b0;
            icm_q       <= '0;
            phy_q       <= '0;
            entry_q     <= '0;
            cnt_q       <= '0;
            del_done_q  <= 1'b0;
            last_done_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wr_q        <= wr_d;
            icm_q       <= icm_d;
            phy_q       <= phy_d;
            entry_q     <= entry_d;
            cnt_q       <= cnt_d;
            del_done_q  <= del_done_d;
            last_done_q <= last_done_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end
endmodule

// File: tb/tb_swacc_ctx_wr_ctl.sv
// tb_swacc_ctx_wr_ctl: directed plus randomized commands against a command-level reference model
module tb_swacc_ctx_wr_ctl;
    localparam int DW  = 256;
    localparam int HW  = 128;
    localparam int P   = 2;
    localparam int EW  = 512;
    localparam int IW  = 20;
    localparam int AW  = 64;
    localparam int TW  = 6;
    localparam int CL  = 3;
    localparam int SHW = TW + 2*CL + 2*AW;
    localparam int DHW = TW + 2*AW;

    logic clk = 1'b0;
    logic rst_n;
    logic req_valid, req_last, req_ready;
    logic [HW-1:0] req_head;
    logic [DW-1:0] req_data;
    logic lookup_valid, lookup_ready;
    logic [IW-1:0] lookup_head;
    logic rsp_valid, rsp_ready;
    logic [AW-1:0] rsp_icm_addr, rsp_phy_addr;
    logic set_valid, set_ready;
    logic [SHW-1:0] set_head;
    logic [EW-1:0] set_data;
    logic del_valid, del_ready;
    logic [DHW-1:0] del_head;
    logic err_valid, busy;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    swacc_ctx_wr_ctl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_head(req_head), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
        .lookup_valid(lookup_valid), .lookup_head(lookup_head), .lookup_ready(lookup_ready),
        .rsp_valid(rsp_valid), .rsp_icm_addr(rsp_icm_addr), .rsp_phy_addr(rsp_phy_addr), .rsp_ready(rsp_ready),
        .set_valid(set_valid), .set_head(set_head), .set_data(set_data), .set_ready(set_ready),
        .del_valid(del_valid), .del_head(del_head), .del_ready(del_ready),
        .err_valid(err_valid), .err_code(err_code), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    logic [IW-1:0]  exp_lk[$];
    logic [SHW-1:0] exp_sh[$];
    logic [EW-1:0]  exp_sd[$];
    logic [DHW-1:0] exp_dh[$];
    logic [1:0]     exp_err[$];
    logic [AW-1:0]  rsp_icm_q[$], rsp_phy_q[$];
    bit rand_rdy = 0, hold_set = 0, hold_del = 0, lat_mode = 0;

    task automatic check(input string name, input logic [639:0] got, input logic [639:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model: expected cache/error traffic derived from the command as a whole
    task automatic send_cmd(input logic [3:0] opc, input logic [IW-1:0] idx, input int n,
                            input logic [AW-1:0] icm, input logic [AW-1:0] phy, input bit gaps);
        logic [HW-1:0] head;
        logic [DW-1:0] d[$];
        logic [EW-1:0] ent;
        bit acc;
        for (int i = 0; i < HW/32; i++) head[i*32 +: 32] = $urandom;
        head[123:120] = opc;
        head[64 +: IW] = idx;
        for (int b = 0; b < n; b++) d.push_back(rand_beat());
        if (opc != 4'h1 && opc != 4'h2) begin
            exp_err.push_back(2'd1);
        end else begin
            exp_lk.push_back(idx);
            rsp_icm_q.push_back(icm);
            rsp_phy_q.push_back(phy);
            if (opc == 4'h2) exp_dh.push_back({TW'(0), phy, icm});
            else if (n < P) exp_err.push_back(2'd2);
            else if (n > P) exp_err.push_back(2'd3);
            else begin
                ent = '0;
                for (int b = 0; b < P; b++) ent[b*DW +: DW] = d[b];
                exp_sh.push_back({TW'(0), CL'(1), CL'(0), phy, icm});
                exp_sd.push_back(ent);
            end
        end
        req_head = head;
        for (int b = 0; b < n; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                req_valid = 1'b0;
                @(posedge clk); #1;
            end
            req_valid = 1'b1;
            req_data  = d[b];
            req_last  = (b == n - 1);
            acc = 0;
            for (int t = 0; t < 300 && !acc; t++) begin
                @(negedge clk);
                acc = req_ready;
                @(posedge clk); #1;
            end
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL beat_accept timeout beat=%0d", b);
                finish_run();
            end
        end
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || exp_lk.size() > 0 || exp_sh.size() > 0 || exp_dh.size() > 0 || exp_err.size() > 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 500) begin
            errors++;
            $display("FAIL idle_timeout busy=%0b lk=%0d set=%0d del=%0d err=%0d required all zero",
                     busy, exp_lk.size(), exp_sh.size(), exp_dh.size(), exp_err.size());
            finish_run();
        end
    endtask

    // Downstream responder: translation service and cache readiness
    initial begin
        bit lk_f, rs_f, pend;
        pend = 0;
        lookup_ready = 1'b0; rsp_valid = 1'b0; rsp_icm_addr = '0; rsp_phy_addr = '0;
        set_ready = 1'b0; del_ready = 1'b0;
        forever begin
            @(negedge clk);
            lk_f = lookup_valid && lookup_ready;
            rs_f = rsp_valid && rsp_ready;
            @(posedge clk); #1;
            if (rs_f) begin
                rsp_valid = 1'b0;
                rsp_icm_q.delete(0);
                rsp_phy_q.delete(0);
            end
            if (lk_f) pend = 1;
            if (pend && !rsp_valid && rsp_icm_q.size() > 0 && (!rand_rdy || $urandom_range(0, 2) == 0)) begin
                rsp_valid    = 1'b1;
                rsp_icm_addr = rsp_icm_q[0];
                rsp_phy_addr = rsp_phy_q[0];
                pend = 0;
            end
            lookup_ready = !rand_rdy || $urandom_range(0, 1) == 1;
            set_ready    = !hold_set && (!rand_rdy || $urandom_range(0, 1) == 1);
            del_ready    = !hold_del && (!rand_rdy || $urandom_range(0, 1) == 1);
        end
    end

    // Monitor: pops expectations whenever the DUT completes a handshake or pulses an error
    initial begin
        int cyc, t0;
        bit armed, pv_lk, pv_set, pv_del;
        logic [1:0] last_code;
        cyc = 0; t0 = 0; armed = 0; pv_lk = 0; pv_set = 0; pv_del = 0; last_code = 2'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pv_lk = 0; pv_set = 0; pv_del = 0; armed = 0; last_code = 2'd0;
                continue;
            end
            if (pv_lk) check("lookup_hold", lookup_valid, 1);
            if (pv_set) check("set_hold", set_valid, 1);
            if (pv_del) check("del_hold", del_valid, 1);
            pv_lk  = lookup_valid && !lookup_ready;
            pv_set = set_valid && !set_ready;
            pv_del = del_valid && !del_ready;
            if (!lookup_valid) check("lookup_head_zero", lookup_head, 0);
            if (!set_valid) check("set_head_zero", set_head, 0);
            if (lat_mode && !armed && req_valid && !busy) begin
                armed = 1;
                t0 = cyc;
            end
            if (armed && set_valid) begin
                check("set_latency", cyc - t0, 3 + P);
                armed = 0;
            end
            if (lookup_valid && lookup_ready) begin
                if (exp_lk.size() == 0) check("lookup_unexpected", 1, 0);
                else check("lookup_head", lookup_head, exp_lk.pop_front());
            end
            if (set_valid && set_ready) begin
                if (exp_sh.size() == 0) check("set_unexpected", 1, 0);
                else begin
                    check("set_head", set_head, exp_sh.pop_front());
                    check("set_data", set_data, exp_sd.pop_front());
                end
            end
            if (del_valid && del_ready) begin
                if (exp_dh.size() == 0) check("del_unexpected", 1, 0);
                else check("del_head", del_head, exp_dh.pop_front());
            end
            if (err_valid) begin
                if (exp_err.size() == 0) check("err_unexpected", 1, 0);
                else begin
                    last_code = exp_err.pop_front();
                    check("err_code", err_code, last_code);
                end
            end else begin
                check("err_code_hold", err_code, last_code);
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog expired");
        finish_run();
    end

    initial begin
        logic [3:0] o;
        rst_n = 1'b0;
        req_valid = 1'b0; req_head = '0; req_last = 1'b0; req_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_lookup_valid", lookup_valid, 0);
        check("rst_rsp_ready", rsp_ready, 0);
        check("rst_set_valid", set_valid, 0);
        check("rst_set_data", set_data, 0);
        check("rst_del_valid", del_valid, 0);
        check("rst_err", {err_valid, err_code}, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        lat_mode = 1;
        send_cmd(4'h1, 20'h15, 2, 64'h1000, 64'h8000, 0);
        wait_idle();
        lat_mode = 0;

        hold_del = 1;
        send_cmd(4'h2, 20'h7, 1, 64'h2000, 64'h9000, 0);
        repeat (5) begin
            @(negedge clk);
            check("del_stall_valid", del_valid, 1);
        end
        hold_del = 0;
        wait_idle();

        send_cmd(4'hF, 20'h3, 3, 64'h0, 64'h0, 0);
        wait_idle();
        send_cmd(4'h1, 20'h21, 1, 64'h3000, 64'hA000, 0);
        send_cmd(4'h1, 20'h22, 2, 64'h4000, 64'hB000, 0);
        wait_idle();
        send_cmd(4'h1, 20'h23, 3, 64'h5000, 64'hC000, 0);
        wait_idle();

        rand_rdy = 1;
        for (int k = 0; k < 60; k++) begin
            o = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 2)) : 4'($urandom_range(0, 15));
            send_cmd(o, IW'($urandom), $urandom_range(1, 4), {$urandom, $urandom}, {$urandom, $urandom}, 1);
        end
        wait_idle();

        rand_rdy = 0;
        hold_set = 1;
        send_cmd(4'h1, 20'h44, 2, 64'h6000, 64'hD000, 0);
        for (int t = 0; t < 50 && !set_valid; t++) @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            check("set_stall_valid", set_valid, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_set_valid", set_valid, 0);
        check("arst_set_head", set_head, 0);
        check("arst_set_data", set_data, 0);
        check("arst_req_ready", req_ready, 0);
        check("arst_lookup", {lookup_valid, lookup_head}, 0);
        check("arst_del", {del_valid, del_head}, 0);
        check("arst_err", {err_valid, err_code}, 0);
        check("arst_busy", busy, 0);
        exp_sh.delete();
        exp_sd.delete();
        hold_set = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_cmd(4'h1, 20'h55, 2, 64'h7000, 64'hE000, 0);
        wait_idle();
        finish_run();
    end
endmodule
